// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: registered main entry with flush redirect and bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_buf #(
  parameter int DATA_W  = 96,
  parameter int CTRL_W  = 24,
  parameter int PC_BIAS = 8
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  output logic [1:0]        occupancy
);

  localparam logic [31:0] PC_BIAS_C = 32'(PC_BIAS);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [1:0]        occ_q, occ_d;
  logic              xfer_in_s;
  logic              xfer_out_s;

`ifdef PIPE_STAGE_SKID_EN
  logic              sk_valid_q, sk_valid_d;
  logic [31:0]       sk_pc_q, sk_pc_d;
  logic [31:0]       sk_inst_q, sk_inst_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;
  logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
  logic              rdy_q, rdy_d;

  assign in_ready = rdy_q;
`else
  assign in_ready = ~valid_q | out_ready;
`endif

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign occupancy = occ_q;

  // Next-state selection: flush first, then skid drain, skid fill, main load, bubble.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    xfer_out_s = valid_q & out_ready;
`ifdef PIPE_STAGE_SKID_EN
    sk_valid_d = sk_valid_q;
    sk_pc_d    = sk_pc_q;
    sk_inst_d  = sk_inst_q;
    sk_data_d  = sk_data_q;
    sk_ctrl_d  = sk_ctrl_q;
    xfer_in_s  = in_valid & rdy_q & ~flush;
`else
    xfer_in_s  = in_valid & (~valid_q | out_ready) & ~flush;
`endif

    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      inst_d  = 32'h0000_0000;
      pc_d    = flush_pc - PC_BIAS_C;
`ifdef PIPE_STAGE_SKID_EN
      sk_valid_d = 1'b0;
      sk_ctrl_d  = '0;
`endif
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (sk_valid_q) begin
        // Skid entry is older than anything upstream, so it refills main first.
        if (xfer_out_s) begin
          valid_d    = 1'b1;
          pc_d       = sk_pc_q;
          inst_d     = sk_inst_q;
          data_d     = sk_data_q;
          ctrl_d     = sk_ctrl_q;
          sk_valid_d = 1'b0;
          sk_ctrl_d  = '0;
        end else begin
          sk_valid_d = 1'b1;
        end
      end else if (xfer_in_s && valid_q && !out_ready) begin
        sk_valid_d = 1'b1;
        sk_pc_d    = in_pc;
        sk_inst_d  = in_inst;
        sk_data_d  = in_data;
        sk_ctrl_d  = in_ctrl;
      end else if (xfer_in_s) begin
`else
      if (xfer_in_s) begin
`endif
        valid_d = 1'b1;
        pc_d    = in_pc;
        inst_d  = in_inst;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else if (xfer_out_s) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d = valid_q;
      end
    end

`ifdef PIPE_STAGE_SKID_EN
    occ_d = {1'b0, valid_d} + {1'b0, sk_valid_d};
    rdy_d = ~sk_valid_d;
`else
    occ_d = {1'b0, valid_d};
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      inst_q  <= 32'h0000_0000;
      data_q  <= '0;
      ctrl_q  <= '0;
      occ_q   <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      sk_valid_q <= 1'b0;
      sk_pc_q    <= 32'h0000_0000;
      sk_inst_q  <= 32'h0000_0000;
      sk_data_q  <= '0;
      sk_ctrl_q  <= '0;
      rdy_q      <= 1'b1;
`endif
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      occ_q   <= occ_d;
`ifdef PIPE_STAGE_SKID_EN
      sk_valid_q <= sk_valid_d;
      sk_pc_q    <= sk_pc_d;
      sk_inst_q  <= sk_inst_d;
      sk_data_q  <= sk_data_d;
      sk_ctrl_q  <= sk_ctrl_d;
      rdy_q      <= rdy_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (default or PIPE_STAGE_SKID_EN build).
module tb_pipe_stage_buf;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 24;

  logic              CLK = 1'b0;
  logic              NRST;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [31:0]       flush_pc;
  logic [1:0]        occupancy;

  int tests = 0;
  int fails = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_BIAS(8)) dut (
    .CLK(CLK), .NRST(NRST), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .flush_pc(flush_pc), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an entry whose inst/data/ctrl are derived from its pc.
  task automatic drive(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = pc ^ 32'hDEAD_0000;
    in_data  = {pc, ~pc, pc};
    in_ctrl  = pc[23:0] | 24'h80_0000;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check full presented entry for a pc driven by drive().
  task automatic chk_entry(input string tag, input logic [31:0] pc);
    logic [DATA_W-1:0] d;
    d = {pc, ~pc, pc};
    chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    chk({tag, "_pc"},    {96'd0, out_pc}, {96'd0, pc});
    chk({tag, "_inst"},  {96'd0, out_inst}, {96'd0, pc ^ 32'hDEAD_0000});
    chk({tag, "_data"},  {32'd0, out_data}, {32'd0, d});
    chk({tag, "_ctrl"},  {104'd0, out_ctrl}, {104'd0, pc[23:0] | 24'h80_0000});
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [1:0] occ, input logic rdy);
    chk({tag, "_ov"},  {127'd0, out_valid}, {127'd0, v});
    chk({tag, "_occ"}, {126'd0, occupancy}, {126'd0, occ});
    chk({tag, "_rdy"}, {127'd0, in_ready}, {127'd0, rdy});
  endtask

  initial begin
    NRST      = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0000_0000;
    out_ready = 1'b0;
    drive(32'hFFFF_FFFF);
    in_ctrl   = 24'hFF_FFFF;

    // Reset with valid input and all-ones control
    step();
    step();
    chk_state("rst", 1'b0, 2'd0, 1'b1);
    chk("rst_ctrl", {104'd0, out_ctrl}, 128'd0);
    chk("rst_pc",   {96'd0, out_pc}, 128'd0);
    chk("rst_inst", {96'd0, out_inst}, 128'd0);
    chk("rst_data", {32'd0, out_data}, 128'd0);
    NRST     = 1'b1;
    in_valid = 1'b0;
    step();
    chk_state("idle", 1'b0, 2'd0, 1'b1);

    // Streaming with no gaps
    out_ready = 1'b1;
    drive(32'h0000_0100);
    step();
    chk_entry("s100", 32'h0000_0100);
    chk_state("s100", 1'b1, 2'd1, 1'b1);
    drive(32'h0000_0104);
    step();
    chk_entry("s104", 32'h0000_0104);
    drive(32'h0000_0108);
    step();
    chk_entry("s108", 32'h0000_0108);
    chk_state("s108", 1'b1, 2'd1, 1'b1);

    // Stall bubble after 0x300 consumed
    drive(32'h0000_0300);
    step();
    chk_entry("b300", 32'h0000_0300);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("bub", 1'b0, 2'd0, 1'b1);
      chk("bub_ctrl", {104'd0, out_ctrl}, 128'd0);
      chk("bub_pc",   {96'd0, out_pc}, 128'h300);
      chk("bub_inst", {96'd0, out_inst}, {96'd0, 32'h0000_0300 ^ 32'hDEAD_0000});
    end

    // Backpressure
    out_ready = 1'b0;
    drive(32'h0000_0200);
    step();
    chk_entry("bp200", 32'h0000_0200);
`ifdef PIPE_STAGE_SKID_EN
    chk_state("bp200", 1'b1, 2'd1, 1'b1);
    drive(32'h0000_0204);
    step();
    chk_entry("bp_hold", 32'h0000_0200);
    chk_state("bp_full", 1'b1, 2'd2, 1'b0);
    in_valid  = 1'b0;
    step();
    chk_entry("bp_stable", 32'h0000_0200);
    chk_state("bp_stable", 1'b1, 2'd2, 1'b0);
    out_ready = 1'b1;
    step();
    chk_entry("bp204", 32'h0000_0204);
    chk_state("bp204", 1'b1, 2'd1, 1'b1);
    step();
    chk_state("bp_empty", 1'b0, 2'd0, 1'b1);
`else
    chk_state("bp200", 1'b1, 2'd1, 1'b0);
    drive(32'h0000_0204);
    step();
    chk_entry("bp_hold", 32'h0000_0200);
    chk_state("bp_hold", 1'b1, 2'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_entry("bp_replace", 32'h0000_0204);
    chk_state("bp_replace", 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    chk_state("bp_empty", 1'b0, 2'd0, 1'b1);
`endif

    // Flush with held entries and a simultaneous push
    out_ready = 1'b0;
    drive(32'h0000_0500);
    step();
`ifdef PIPE_STAGE_SKID_EN
    drive(32'h0000_0504);
    step();
    chk_state("pre_fl", 1'b1, 2'd2, 1'b0);
`else
    chk_state("pre_fl", 1'b1, 2'd1, 1'b0);
`endif
    drive(32'h0000_0508);
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h0000_1000;
    step();
    chk_state("fl", 1'b0, 2'd0, 1'b1);
    chk("fl_ctrl", {104'd0, out_ctrl}, 128'd0);
    chk("fl_inst", {96'd0, out_inst}, 128'd0);
    chk("fl_pc",   {96'd0, out_pc}, 128'hFF8);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_state("fl_after", 1'b0, 2'd0, 1'b1);

    // Flush redirect wraps modulo 2^32
    out_ready = 1'b0;
    drive(32'h0000_0600);
    step();
    flush    = 1'b1;
    flush_pc = 32'h0000_0004;
    step();
    chk("flw_pc", {96'd0, out_pc}, {96'd0, 32'hFFFF_FFFC});
    chk_state("flw", 1'b0, 2'd0, 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Reset dominates flush and transfers mid-stall
    drive(32'h0000_0700);
    step();
`ifdef PIPE_STAGE_SKID_EN
    drive(32'h0000_0704);
    step();
`endif
    chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    NRST      = 1'b0;
    flush     = 1'b1;
    flush_pc  = 32'h0000_2000;
    out_ready = 1'b1;
    drive(32'h0000_0708);
    step();
    chk_state("rst2", 1'b0, 2'd0, 1'b1);
    chk("rst2_pc",   {96'd0, out_pc}, 128'd0);
    chk("rst2_ctrl", {104'd0, out_ctrl}, 128'd0);
    chk("rst2_data", {32'd0, out_data}, 128'd0);
    NRST     = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, 96, width of the operand payload (e.g. source1, source2, imm).
REQ-002 Parameter CTRL_W, 24, width of the control bundle (alu, jump, branch, mem, reg_write, predict flags).
REQ-003 Parameter PC_BIAS, 8, constant subtracted from flush_pc when forming the post-flush bubble PC.
REQ-004 CLK  input  1  clock; all state updates on its rising edge.
REQ-005 NRST  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream entry valid.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_pc, in_inst  input  32 each  upstream PC and instruction word.
REQ-009 in_data  input  DATA_W  upstream operand payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 out_valid  output  1  downstream entry valid.
REQ-012 out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 out_pc, out_inst  output  32 each  registered PC and instruction.
REQ-014 out_data  output  DATA_W  registered payload.
REQ-015 out_ctrl  output  CTRL_W  registered control; all-zero whenever out_valid=0.
REQ-016 flush  input  1  mispredict kill of every held and incoming entry.
REQ-017 flush_pc  input  32  redirect target accompanying flush.
REQ-018 occupancy  output  2  number of valid entries held (0..2).

Function
REQ-019 Transfer in: in_valid & in_ready & !flush; transfer out: out_valid & out_ready.
REQ-020 Latency: an entry accepted in cycle N SHALL be presented on out_* in cycle N+1 if the stage was empty or draining.
REQ-021 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-022 Main register drives out_*; while out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-023 in_valid=0 (stall) with main drained SHALL present a bubble: out_valid=0, out_ctrl=0, out_pc/out_inst/out_data hold previous values.
REQ-024 flush=1 SHALL, at the next edge, clear all entries (occupancy=0, out_valid=0, out_ctrl=0, out_inst=0), load out_pc=flush_pc-PC_BIAS (modulo 2^32), and ignore in_valid that cycle.
REQ-025 flush SHALL take priority over simultaneous transfer in and transfer out.
REQ-026 Simultaneous transfer in and out with one entry held SHALL replace it; occupancy unchanged.
REQ-027 occupancy SHALL be registered and consistent with out_valid (out_valid = occupancy!=0).

Reset
REQ-028 NRST=0 at an edge SHALL zero all outputs and internal state: out_valid=0, occupancy=0, out_pc/out_inst/out_data/out_ctrl=0; in_ready=1 from the first cycle after reset.
REQ-029 Reset SHALL dominate flush and all transfers, including mid-stall with two entries held.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: a second (skid) entry SHALL exist; in_ready SHALL be a register output equal to (skid empty); a transfer in while main is full and out_ready=0 SHALL land in skid; skid moves to main on the next transfer out; occupancy reaches 2.
REQ-031 Macro undefined: single entry only; in_ready = !out_valid | out_ready (combinational); occupancy never exceeds 1; all other requirements unchanged.

Verification
REQ-032 Reset: NRST=0 two cycles with in_valid=1, in_ctrl=all-ones -> out_valid=0, out_ctrl=0, out_pc=0, occupancy=0, in_ready=1.
REQ-033 Stream: out_ready=1, in_valid=1, in_pc=0x100,0x104,0x108 consecutive -> out_pc 0x100,0x104,0x108 one cycle later each, no gaps.
REQ-034 Backpressure (SKID_EN): out_ready=0, push pc 0x200 then 0x204 -> occupancy=2, in_ready=0, out_pc holds 0x200; release out_ready -> 0x200 then 0x204 in order.
REQ-035 Flush: two entries held, flush=1, flush_pc=0x1000, in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_inst=0, out_pc=0xFF8, occupancy=0.
REQ-036 Flush wrap: flush_pc=0x4 -> out_pc=0xFFFFFFFC.
REQ-037 Stall bubble: in_valid=0 for 3 cycles after pc 0x300 consumed -> out_valid=0, out_ctrl=0, out_pc holds 0x300.
